// File: rtl/vga_pkg.sv
// Shared constants and types for the 640x480@60 Hz display path.
// Each timing stage and its derived positions are in one place, so the
// sync generator and the pixel-generation stage agree on them.
package vga_pkg;

  // Screen coordinate: wide enough for every horizontal and vertical position.
  typedef logic [10:0] coord_t;

  // System clocks per pixel (4 at 100 MHz, 2 at 50 MHz).
  localparam int VGA_CLK_DIV      = 4;

  // Horizontal timing, in pixels.
  localparam int VGA_H_DISPLAY    = 640;
  localparam int VGA_H_FRONT      = 16;
  localparam int VGA_H_SYNC       = 96;
  localparam int VGA_H_BACK       = 48;
  localparam int VGA_H_TOTAL      = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;

  // Vertical timing, in lines.
  localparam int VGA_V_DISPLAY    = 480;
  localparam int VGA_V_FRONT      = 10;
  localparam int VGA_V_SYNC       = 2;
  localparam int VGA_V_BACK       = 33;
  localparam int VGA_V_TOTAL      = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  localparam int VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FRONT;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

endpackage

// File: rtl/pix_tick_gen.sv
// Rate generator: a free-running divider that emits a one-clk strobe
// every CLK_DIV system clocks. CLK_DIV must be at least 2, so the strobe
// is low while the divider is held in reset.
module pix_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Count 0..CLK_DIV-1 and wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign p_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator. Divides the system clock to the pixel rate and
// runs the horizontal and vertical counters through the full blanking
// range. hsync, vsync and video_on are decoded from the next counter
// values and registered on the same edge as the counters, so they always
// describe the current pix_x/pix_y with no extra latency.
module vga_sync
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = VGA_CLK_DIV,
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic        clk,
  input  logic        reset,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        p_tick,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        frame_tick
);

  localparam coord_t H_LAST  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t H_VIS   = coord_t'(H_DISPLAY);
  localparam coord_t H_SS    = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t H_SE    = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t V_LAST  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t V_VIS   = coord_t'(V_DISPLAY);
  localparam coord_t V_SS    = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t V_SE    = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  coord_t x_next;
  coord_t y_next;
  logic   h_end;
  logic   v_end;

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  // Compares happen on the current value, before any increment, so the
  // counters never need a wider intermediate.
  assign h_end = (pix_x == H_LAST);
  assign v_end = (pix_y == V_LAST);

  // Next counter values: x advances on every pixel strobe, y advances only
  // when x wraps, and both wrap together at the last pixel of the frame.
  always_comb begin
    x_next = pix_x;
    y_next = pix_y;
    if (p_tick) begin
      if (h_end) begin
        x_next = '0;
        y_next = v_end ? coord_t'(0) : pix_y + 11'd1;
      end else begin
        x_next = pix_x + 11'd1;
      end
    end
  end

  // Counters plus registered decode of the values they are about to take.
  // The reset values are the decode of pixel (0,0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_x    <= '0;
      pix_y    <= '0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b1;
    end else begin
      pix_x    <= x_next;
      pix_y    <= y_next;
      hsync    <= !((x_next >= H_SS) && (x_next <= H_SE));
      vsync    <= !((y_next >= V_SS) && (y_next <= V_SE));
      video_on <= (x_next < H_VIS) && (y_next < V_VIS);
    end
  end

  // Once-per-frame strobe on the pixel strobe that wraps both counters.
  assign frame_tick = p_tick && h_end && v_end;

endmodule

// File: doc/vga_sync.md
# vga_sync

Timing generator for the 640x480@60 Hz display path. It divides the system clock down to the pixel rate and runs horizontal and vertical counters. It produces `hsync`/`vsync`, `video_on`, `pix_x`/`pix_y` and strobes for the downstream pixel-generation stage, which consumes `video_on`, `pix_x` and `pix_y` to draw walls, player and bullet. The game logic uses `frame_tick` as its once-per-frame update strobe.

## Interface

- `CLK_DIV`, 4: system clocks per pixel; must be ≥2 (4 for 100 MHz, 2 for 50 MHz).
- `H_DISPLAY`, 640; `H_FRONT`, 16; `H_SYNC`, 96; `H_BACK`, 48: horizontal timing in pixels. `H_TOTAL` = 800.
- `V_DISPLAY`, 480; `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33: vertical timing in lines. `V_TOTAL` = 525.

Ports:

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `hsync` out 1: horizontal sync, active-low, registered.
- `vsync` out 1: vertical sync, active-low, registered.
- `video_on` out 1: high while the pixel is inside the visible 640x480 area, registered.
- `p_tick` out 1: one-clk strobe; counters and sync outputs update on the next rising edge.
- `pix_x` out 11: horizontal counter, 0..H_TOTAL-1.
- `pix_y` out 11: vertical counter, 0..V_TOTAL-1.
- `frame_tick` out 1: one-clk strobe on the last `p_tick` of each frame.

## Operation

- **Divider.** `div_cnt` counts 0..CLK_DIV-1 every clk and wraps to 0. `p_tick` = (`div_cnt` == CLK_DIV-1), combinational from `div_cnt`.
- **Horizontal counter.** On a clk edge with `p_tick` high, `pix_x` increments. At H_TOTAL-1 it wraps to 0.
- **Vertical counter.** `pix_y` increments only on the `p_tick` edge where `pix_x` wraps. At V_TOTAL-1 it wraps to 0.
- **Counter range.** Counters traverse the full blanking range, so `pix_y` reaches 480..524. The downstream stage relies on `pix_y` == 481.
- **Registered decode.** `hsync`, `vsync` and `video_on` are decoded from the next counter values and loaded on the same edge as the counters. They are therefore always aligned with the current `pix_x`/`pix_y`.
  - `hsync` = 0 iff 656 ≤ x ≤ 751.
  - `vsync` = 0 iff 490 ≤ y ≤ 491.
  - `video_on` = 1 iff x < 640 and y < 480.
- **Frame strobe.** `frame_tick` = `p_tick` and `pix_x` == 799 and `pix_y` == 524, combinational.
- **Width.** All arithmetic uses 11-bit unsigned values. The compare against H_TOTAL-1 or V_TOTAL-1 happens before increment, so there is no overflow.

## Timing

- **Reset values** (`reset` low, asynchronous): `div_cnt` 0, `pix_x` 0, `pix_y` 0, `hsync` 1, `vsync` 1, `video_on` 1 (the decode of pixel 0,0). `p_tick` 0 and `frame_tick` 0, which follows because CLK_DIV ≥ 2.
- **First advance.** After `reset` deasserts, the first `p_tick` is asserted in clk CLK_DIV-1. `pix_x` becomes 1 at the CLK_DIV-th rising edge.
- **Pixel and frame periods.**
  - Pixel (0,0) lasts CLK_DIV clks from release; every pixel lasts exactly CLK_DIV clks.
  - Line = 800·CLK_DIV clks. Frame = 420000·CLK_DIV clks.
- **Latency.** Zero: sync and `video_on` change on the same edge as `pix_x`/`pix_y`.
- **Reset mid-frame.** All registers clear immediately (asynchronous). The frame restarts at (0,0) with no partial strobe.
- **Simultaneous wrap.** At `pix_x` == 799 and `pix_y` == 524 with `p_tick`, both counters go to 0 on the same edge. `frame_tick` is high for that one clk only.

## Structure

- **Shared package `vga_pkg`.** Holds the timing constants, the derived `H_TOTAL`/`V_TOTAL`, the sync-start and sync-end positions, and the 11-bit coordinate typedef. The display-path stages share it.
- **Sub-module `pix_tick_gen`.** Holds `div_cnt` and `p_tick`, parameterised by CLK_DIV. It is reused by the game logic for rate generation.
- **Top level.** Counters and registered decode stay in the top level. Implementation is about 150 lines.

## Test plan

- **Reset state.** Hold `reset` low 10 clks, then release. Required: during reset, `pix_x`=`pix_y`=0, `hsync`=`vsync`=1, `video_on`=1, `p_tick`=0. First `p_tick` at clk 3 (CLK_DIV=4); `pix_x`=1 after edge 4.
- **Horizontal timing.** Run one line with CLK_DIV=4.
  - `hsync` low for exactly 384 clks, starting on the edge `pix_x` becomes 656.
  - `video_on` high for 2560 clks per visible line.
  - Line length is 3200 clks.
- **Vertical timing and frame.** Run 2 frames.
  - `vsync` low for exactly 6400 clks, starting where `pix_y` becomes 490.
  - `frame_tick` pulses are 1,680,000 clks apart and 1 clk wide.
  - `video_on` high for 307200 pixels per frame.
  - `pix_y` == 481 with `pix_x` == 0 occurs once per frame.
- **Reset mid-frame.** Assert `reset` at `pix_x`=300, `pix_y`=200, between clk edges. Required: outputs go to reset values without waiting for a clk edge, and no `frame_tick` is generated. After release, timing matches the reset-state scenario.
- **Parameter variant.** With CLK_DIV=2, line = 1600 clks, frame = 840000 clks, `hsync` low 192 clks.
- **Wrap corner.** Observe the edge at (799,524). Required: both counters become 0 on the same edge, `video_on` rises to 1 at that edge, and `hsync`/`vsync` are 1.
